// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int unsigned     XLEN             = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
  } if_bundle_t;

  // Value presented on the decode outputs while the queue has never been written.
  localparam if_bundle_t IF_BUNDLE_RST = '{instr: '0, pc: '0, pc_plus4: XLEN'(4)};

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetch bundles with flush; head is read straight from storage flops.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH   = 2,
  parameter if_bundle_t  RST_VAL = '0,
  localparam int unsigned AW     = $clog2(DEPTH),
  localparam int unsigned CW     = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  if_bundle_t    push_data,
  input  logic          pop,
  output if_bundle_t    head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  if_bundle_t    mem_q [DEPTH];
  if_bundle_t    mem_d [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  // A push into a full queue is accepted only when the head leaves in the same cycle.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= RST_VAL;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues credit-limited word reads,
// buffers returned instructions for decode and squashes wrong-path fetches on redirect.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int unsigned     QUEUE_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_PC,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            if_valid,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_PC,
  output logic [XLEN-1:0] if_PC_plus4,
  input  logic            id_ready
);

  localparam int unsigned CW = $clog2(QUEUE_DEPTH + 1);
  localparam int unsigned SW = CW + 1;

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   out_q, out_d;
  logic [CW-1:0]   drop_q, drop_d;

  logic            credit_ok, grant, rsp, drop_rsp, keep_rsp, iq_pop;
  if_bundle_t      trk_push_data, trk_head, iq_push_data, iq_head;
  logic [CW-1:0]   trk_count, iq_count;
  logic            trk_full, trk_empty, iq_full, iq_empty;

  // Next-state and request logic; credits come only from registered counts.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    out_d         = out_q;
    drop_d        = drop_q;
    credit_ok     = (SW'(out_q) + SW'(iq_count)) < SW'(QUEUE_DEPTH);
    imem_req      = (state_q == RUN) && credit_ok && !redirect_valid;
    grant         = imem_req && imem_gnt;
    rsp           = imem_rvalid && (out_q != '0);
    drop_rsp      = rsp && (redirect_valid || (drop_q != '0));
    keep_rsp      = rsp && !drop_rsp;
    iq_pop        = !iq_empty && id_ready && !redirect_valid;
    trk_push_data = '{instr: '0, pc: pc_q, pc_plus4: pc_q + XLEN'(4)};
    iq_push_data  = trk_head;
    iq_push_data.instr = imem_rdata;

    if (state_q == BOOT) begin
      state_d = RUN;
    end

    out_d = out_q + CW'(grant) - CW'(rsp);
    // Everything still in flight after a redirect belongs to the old path.
    if (redirect_valid) begin
      pc_d   = word_align(redirect_PC);
      drop_d = out_d;
    end else begin
      if (grant) begin
        pc_d = pc_q + XLEN'(4);
      end
      if (drop_rsp) begin
        drop_d = drop_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      out_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      out_q   <= out_d;
      drop_q  <= drop_d;
    end
  end

  fetch_queue #(
    .DEPTH   (QUEUE_DEPTH),
    .RST_VAL ('0)
  ) u_tracker (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (grant),
    .push_data (trk_push_data),
    .pop       (keep_rsp),
    .head      (trk_head),
    .count     (trk_count),
    .full      (trk_full),
    .empty     (trk_empty)
  );

  fetch_queue #(
    .DEPTH   (QUEUE_DEPTH),
    .RST_VAL (IF_BUNDLE_RST)
  ) u_iq (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (keep_rsp),
    .push_data (iq_push_data),
    .pop       (iq_pop),
    .head      (iq_head),
    .count     (iq_count),
    .full      (iq_full),
    .empty     (iq_empty)
  );

  assign imem_addr   = pc_q;
  assign if_valid    = !iq_empty;
  assign if_instr    = iq_head.instr;
  assign if_PC       = iq_head.pc;
  assign if_PC_plus4 = iq_head.pc_plus4;

  // Every outstanding read is either tracked for delivery or pending a drop.
  a_track_balance: assert property (@(posedge clk) disable iff (rst)
    (SW'(trk_count) + SW'(drop_q)) == SW'(out_q));
  a_out_bound: assert property (@(posedge clk) disable iff (rst)
    out_q <= CW'(QUEUE_DEPTH));
  a_trk_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(trk_full && grant));
  a_trk_no_underflow: assert property (@(posedge clk) disable iff (rst)
    !(trk_empty && keep_rsp));
  a_iq_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(iq_full && keep_rsp && !iq_pop));

endmodule
